// File: rtl/press_classify_pkg.sv
// press_classify_pkg: shared types and default constants for the key-press classifier.
//   state_t          - classifier FSM state encoding (3 bits; codes 5..7 are illegal)
//   LONG_TICKS_DEF   - default en-ticks of continuous press for a long press
//   DBL_TICKS_DEF    - default en-ticks of release gap for a double click
//   CW_DEF           - default tick counter width
package press_classify_pkg;

    localparam int unsigned LONG_TICKS_DEF = 100;
    localparam int unsigned DBL_TICKS_DEF  = 30;
    localparam int unsigned CW_DEF         = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS  = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } state_t;

endpackage

// File: rtl/press_classify_sat_cnt.sv
// sat_cnt: CW-bit tick counter with synchronous clear, enable-increment and
// saturation at all-ones.
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset (count -> 0)
//   clr  - clear to zero (wins over inc)
//   inc  - increment by one, holding at 2^CW-1
//   cnt  - current count
module sat_cnt #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CW{1'b1}})) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/press_classify.sv
// press_classify: classifies a debounced key level into short press, long
// press and double click events, advancing only on prescaler ticks (en).
//   clk     - sole clock, rising edge
//   rst     - asynchronous active-high reset
//   en      - tick qualifier shared with the upstream glitch filter
//   i       - debounced key level, 1 = pressed
//   short_p - one-clk pulse, short press
//   long_p  - one-clk pulse, long-press threshold reached
//   dbl_p   - one-clk pulse, double click
//   held    - level, high while in the long-hold state
// Build option: define PRESS_CLASSIFY_DBL_EN to enable double-click detection
// (GAP/PRESS2 states). Without it a release from PRESS reports short_p at once,
// dbl_p is tied low and DBL_TICKS is only range-checked.
module press_classify
    import press_classify_pkg::*;
#(
    parameter int unsigned LONG_TICKS = LONG_TICKS_DEF,
    parameter int unsigned DBL_TICKS  = DBL_TICKS_DEF,
    parameter int unsigned CW         = CW_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic i,
    output logic short_p,
    output logic long_p,
    output logic dbl_p,
    output logic held
);

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);

    // Reject parameter sets the counter cannot represent.
    if ((CW < 2) || (CW > 31) ||
        (LONG_TICKS < 2) || (LONG_TICKS > ((1 << CW) - 1)) ||
        (DBL_TICKS  < 2) || (DBL_TICKS  > ((1 << CW) - 1))) begin : g_param_check
        $error("press_classify: LONG_TICKS/DBL_TICKS must lie in 2..2^CW-1");
    end

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          short_n;
    logic          long_n;

`ifdef PRESS_CLASSIFY_DBL_EN
    localparam logic [CW-1:0] DBL_LAST = CW'(DBL_TICKS - 1);
    logic          dbl_n;
`endif

    // Tick counter: restarts on every state change, runs in timed states.
    assign cnt_clr = (state_nxt != state);
    assign cnt_inc = en && ((state == PRESS) || (state == GAP) || (state == PRESS2));

    sat_cnt #(
        .CW (CW)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (cnt)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and pulse requests; nothing moves between en ticks.
    always_comb begin
        state_nxt = state;
        short_n   = 1'b0;
        long_n    = 1'b0;
`ifdef PRESS_CLASSIFY_DBL_EN
        dbl_n     = 1'b0;
`endif
        if (en) begin
            case (state)
                IDLE: begin
                    if (i) begin
                        state_nxt = PRESS;
                    end
                end
                PRESS: begin
                    // Release outranks the long threshold on the same tick.
                    if (!i) begin
`ifdef PRESS_CLASSIFY_DBL_EN
                        state_nxt = GAP;
`else
                        state_nxt = IDLE;
                        short_n   = 1'b1;
`endif
                    end else if (cnt == LONG_LAST) begin
                        state_nxt = LONG;
                        long_n    = 1'b1;
                    end
                end
`ifdef PRESS_CLASSIFY_DBL_EN
                GAP: begin
                    // A second press outranks gap expiry on the same tick.
                    if (i) begin
                        state_nxt = PRESS2;
                    end else if (cnt == DBL_LAST) begin
                        state_nxt = IDLE;
                        short_n   = 1'b1;
                    end
                end
                PRESS2: begin
                    // Holding the second press still counts as a double click.
                    if (!i) begin
                        state_nxt = IDLE;
                        dbl_n     = 1'b1;
                    end else if (cnt == LONG_LAST) begin
                        state_nxt = LONG;
                        dbl_n     = 1'b1;
                    end
                end
`endif
                LONG: begin
                    if (!i) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Registered outputs: pulses last exactly the cycle after the tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            short_p <= 1'b0;
            long_p  <= 1'b0;
            held    <= 1'b0;
        end else begin
            short_p <= short_n;
            long_p  <= long_n;
            held    <= (state_nxt == LONG);
        end
    end

`ifdef PRESS_CLASSIFY_DBL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbl_p <= 1'b0;
        end else begin
            dbl_p <= dbl_n;
        end
    end
`else
    assign dbl_p = 1'b0;
`endif

endmodule
